gemm_dot_accum_pipe: RTL
========================

Name: gemm_dot_accum_pipe

Overview:
Parametrised, fully pipelined signed dot-product engine for the GEMM datapath. Each accepted beat multiplies N element pairs and reduces them through a registered adder tree. The tree sums of a beat group are accumulated until in_last, then the group result is emitted. Includes ready/valid backpressure, saturation and a sticky overflow flag. Intended as the per-output-element compute unit of the GEMM array, consuming K-length rows as K/N beats.

Parameters:
WIDTH, 16, signed element width of in_a/in_b lanes
N, 8, lanes per beat; power of 2, >= 2
LOG2N, $clog2(N), adder tree depth (derived, not overridden)
ACC_W, 48, signed accumulator/output width; must be >= 2*WIDTH+LOG2N

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  beat present
in_ready  out  1  block can accept beat this cycle
in_a  in  N*WIDTH  lane i = bits [i*WIDTH +: WIDTH], signed
in_b  in  N*WIDTH  same packing as in_a
in_last  in  1  beat is final of accumulation group
out_valid  out  1  group result available
out_ready  in  1  consumer accepts result
out_data  out  ACC_W  saturated signed group sum
out_ovf  out  1  saturation occurred anywhere in this group

Behaviour:
- Reset (async, any time incl. mid-group): all stage valid bits, out_valid, out_ovf, out_data, accumulator = 0; first-beat flag = 1; in-flight beats discarded. in_ready is 1 after reset.
- Beat accepted on a rising edge when in_valid && in_ready.
- stall = out_valid && !out_ready; in_ready = !stall. The whole pipeline (mult, tree, accumulator) holds while stall; no bubbles collapse, no data lost.
- Stage M (1 reg): product[i] = in_a[i]*in_b[i], 2*WIDTH signed, exact.
- Tree stages T1..T_LOG2N (1 reg each): pairwise sums, width grows 1 bit per level, exact; final sum 2*WIDTH+LOG2N bits.
- Each stage carries valid and last sideband alongside data.
- Accumulate stage A: on valid tree output: base = first ? 0 : acc; s = base + sign-extended sum, computed at ACC_W+1 bits; if s > 2^(ACC_W-1)-1 clamp to max, if s < -2^(ACC_W-1) clamp to min, set group ovf. acc <= clamped; first <= last.
- If last: out_data <= clamped, out_ovf <= group ovf (incl. this beat), out_valid <= 1, group ovf cleared.
- Latency: counting the acceptance edge of the last beat as edge 1, out_valid rises after edge LOG2N+2 (N=8: edge 5).
- Throughput: one beat per cycle when out_ready held high; back-to-back groups without gaps; single-beat groups (in_last on every beat) allowed.
- out_valid clears on an edge with out_ready=1 unless a new result lands the same edge (then stays 1 with new data).
- out_data/out_ovf stable while out_valid && !out_ready.
- in_valid=0 beats: bubbles propagate; accumulator untouched.
- Inputs sampled only when accepted; in_a/in_b/in_last are don't-care otherwise.

Test Plan:
- N=8, out_ready=1; one beat, all lanes a=3, b=-2, in_last=1 -> out_data=-48, out_ovf=0, out_valid rises after 5th edge, high 1 cycle.
- 4-beat group; beat k lanes a=k+1, b=1 (k=0..3); last on beat 3 -> single result 80; no out_valid on beats 0-2.
- Two back-to-back 1-beat groups (sums 8, then -8) in consecutive cycles -> out_valid high 2 consecutive cycles, data 8 then -8.
- ACC_W=36; 4-beat group, all lanes a=b=-32768 -> out_data=2^35-1, out_ovf=1. Next 1-beat group a=b=1 -> out_data=8, out_ovf=0.
- out_ready=0 when result pending while input streams -> in_ready drops the next cycle; hold 3 cycles; out_data unchanged; release -> all beats yield correct sums, none lost or duplicated.
- Assert rst mid-group after 2 of 4 beats; then send a fresh 1-beat group (sum 5) -> out_data=5; no stale result or partial accumulation appears.

Source files
------------

// File: rtl/gemm_dot_accum_pipe_if.sv
// Handshake bundle for the dot-product engine: beat input stream and group result stream.
interface gemm_dot_accum_pipe_if #(
   parameter int WIDTH = 16,
   parameter int N     = 8,
   parameter int ACC_W = 48
);
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] in_a;
   logic [N*WIDTH-1:0] in_b;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_W-1:0]   out_data;
   logic               out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/gemm_dot_accum_pipe.sv
// Pipelined signed dot-product engine: N-lane multiply, registered adder tree and a
// saturating group accumulator with sticky overflow, all frozen by output backpressure.
module gemm_dot_accum_pipe #(
   parameter int WIDTH = 16,
   parameter int N     = 8,
   parameter int ACC_W = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   gemm_dot_accum_pipe_if.slave io
);
   localparam int LOG2N = $clog2(N);
   localparam int PW    = 2 * WIDTH;
   localparam int SW    = PW + LOG2N;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic                    stall_s;
   logic                    en_s;
   logic                    accept_s;
   logic signed [WIDTH-1:0] a_s    [N];
   logic signed [WIDTH-1:0] b_s    [N];
   logic signed [PW-1:0]    prod_s [N];
   logic [LOG2N:0]          vld_r;
   logic [LOG2N:0]          lst_r;
   logic signed [SW-1:0]    tree_sum_s;
   logic [ACC_W:0]          base_s;
   logic [ACC_W:0]          sum_s;
   logic [ACC_W-1:0]        clamp_s;
   logic                    sat_s;
   logic [ACC_W-1:0]        acc_r;
   logic                    first_r;
   logic                    grp_ovf_r;
   logic                    out_valid_r;
   logic [ACC_W-1:0]        out_data_r;
   logic                    out_ovf_r;

   // Handshake decode and exact lane products.
   always_comb begin
      stall_s  = out_valid_r && !io.out_ready;
      en_s     = !stall_s;
      accept_s = io.in_valid && en_s;
      for (int i = 0; i < N; i++) begin
         a_s[i]    = io.in_a[i*WIDTH +: WIDTH];
         b_s[i]    = io.in_b[i*WIDTH +: WIDTH];
         prod_s[i] = $signed({{WIDTH{a_s[i][WIDTH-1]}}, a_s[i]})
                   * $signed({{WIDTH{b_s[i][WIDTH-1]}}, b_s[i]});
      end
   end

   // Valid/last sideband, bit 0 = product stage, bit LOG2N = final tree stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= {(LOG2N+1){1'b0}};
         lst_r <= {(LOG2N+1){1'b0}};
      end else if (en_s) begin
         vld_r <= {vld_r[LOG2N-1:0], accept_s};
         lst_r <= {lst_r[LOG2N-1:0], io.in_last};
      end
   end

   for (genvar l = 0; l <= LOG2N; l++) begin : g_lvl
      localparam int CNT = N >> l;
      localparam int LW  = PW + l;
      logic signed [LW-1:0] sum_r [CNT];

      if (l == 0) begin : g_mul
         // Product register stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int j = 0; j < CNT; j++) sum_r[j] <= {LW{1'b0}};
            end else if (en_s) begin
               for (int j = 0; j < CNT; j++) sum_r[j] <= prod_s[j];
            end
         end
      end else begin : g_add
         // Pairwise sums, one bit wider than the level below so nothing wraps.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int j = 0; j < CNT; j++) sum_r[j] <= {LW{1'b0}};
            end else if (en_s) begin
               for (int j = 0; j < CNT; j++) begin
                  sum_r[j] <= $signed({g_lvl[l-1].sum_r[2*j][LW-2],   g_lvl[l-1].sum_r[2*j]})
                            + $signed({g_lvl[l-1].sum_r[2*j+1][LW-2], g_lvl[l-1].sum_r[2*j+1]});
               end
            end
         end
      end
   end

   assign tree_sum_s = g_lvl[LOG2N].sum_r[0];

   // Saturating accumulate; one guard bit is enough since |tree sum| <= 2^(ACC_W-1).
   always_comb begin
      if (first_r) begin
         base_s = {(ACC_W+1){1'b0}};
      end else begin
         base_s = {acc_r[ACC_W-1], acc_r};
      end
      sum_s = base_s + {{(ACC_W+1-SW){tree_sum_s[SW-1]}}, tree_sum_s};
      sat_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
      if (!sat_s) begin
         clamp_s = sum_s[ACC_W-1:0];
      end else if (sum_s[ACC_W]) begin
         clamp_s = ACC_MIN;
      end else begin
         clamp_s = ACC_MAX;
      end
   end

   // Accumulator, group overflow and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r       <= {ACC_W{1'b0}};
         first_r     <= 1'b1;
         grp_ovf_r   <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {ACC_W{1'b0}};
         out_ovf_r   <= 1'b0;
      end else if (en_s) begin
         if (vld_r[LOG2N]) begin
            acc_r   <= clamp_s;
            first_r <= lst_r[LOG2N];
            if (lst_r[LOG2N]) begin
               out_data_r  <= clamp_s;
               out_ovf_r   <= grp_ovf_r | sat_s;
               out_valid_r <= 1'b1;
               grp_ovf_r   <= 1'b0;
            end else begin
               grp_ovf_r   <= grp_ovf_r | sat_s;
               out_valid_r <= 1'b0;
            end
         end else begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign io.in_ready  = en_s;
   assign io.out_valid = out_valid_r;
   assign io.out_data  = out_data_r;
   assign io.out_ovf   = out_ovf_r;
endmodule
